// File: rtl/carrier_mix_sched_if.sv
// Handshake and mixer bus of carrier_mix_sched: sample input, shared-mixer request/result, I/Q output.
interface carrier_mix_sched_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sync;
  logic             mix_start;
  logic [3:0]       mix_phase;
  logic [WIDTH-1:0] mix_data;
  logic [WIDTH-1:0] mix_result;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] q_data;
  logic             out_valid;
  logic             sym_end;
  logic             busy;

  modport master (
    output enable, in_data, in_valid, sync, mix_result,
    input  in_ready, mix_start, mix_phase, mix_data, i_data, q_data, out_valid, sym_end, busy
  );

  modport slave (
    input  enable, in_data, in_valid, sync, mix_result,
    output in_ready, mix_start, mix_phase, mix_data, i_data, q_data, out_valid, sym_end, busy
  );
endinterface

// File: rtl/carrier_mix_sched.sv
// Time-shares one carrier mixer between Q (phase p) and I (phase p+4); I/Q pair out MIX_LAT+3 cycles after accept.
// in_ready drops in ISSUE_Q and while enable is low; define CARRIER_MIX_SYNC_EN to let sync restart the symbol at phase 0.
module carrier_mix_sched #(
  parameter int WIDTH   = 16,
  parameter int MIX_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  carrier_mix_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE_Q, ISSUE_I} state_t;

  typedef struct packed {
    logic vld;
    logic is_i;
    logic last;
  } tag_t;

`ifdef CARRIER_MIX_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  state_t           state;
  logic [3:0]       ph;
  logic [3:0]       ph_next;
  logic [3:0]       mix_phase_r;
  logic             mix_start_r;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] q_hold;
  logic [WIDTH-1:0] i_data_r;
  logic [WIDTH-1:0] q_data_r;
  logic             out_valid_r;
  logic             sym_end_r;
  tag_t             tags [MIX_LAT];
  tag_t             tag_in;
  tag_t             tag_out;
  logic             accept;
  logic             sync_hit;
  logic             tags_busy;

  assign bus.in_ready = bus.enable & ((state == IDLE) | (state == ISSUE_I));
  assign accept       = bus.in_valid & bus.in_ready;
  assign sync_hit     = SYNC_EN & accept & bus.sync;

  // Phase for the next sample: advances after every I request, sync forces a fresh symbol.
  always_comb begin
    ph_next = (state == ISSUE_I) ? ph + 4'd1 : ph;
    if (sync_hit) begin
      ph_next = 4'd0;
    end
  end

  always_comb begin
    tag_in.vld  = (state != IDLE);
    tag_in.is_i = (state == ISSUE_I);
    tag_in.last = (state == ISSUE_I) & (ph == 4'd15);
  end

  assign tag_out = tags[MIX_LAT-1];

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k < MIX_LAT; k++) begin
      tags_busy = tags_busy | tags[k].vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ph          <= 4'd0;
      mix_phase_r <= 4'd0;
      mix_start_r <= 1'b0;
      hold        <= '0;
      q_hold      <= '0;
      i_data_r    <= '0;
      q_data_r    <= '0;
      out_valid_r <= 1'b0;
      sym_end_r   <= 1'b0;
      for (int k = 0; k < MIX_LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      sym_end_r   <= 1'b0;

      // Tag pipeline mirrors the mixer latency so results pair with their request type.
      tags[0] <= tag_in;
      for (int k = 1; k < MIX_LAT; k++) begin
        tags[k] <= tags[k-1];
      end

      if (tag_out.vld && !tag_out.is_i) begin
        q_hold <= bus.mix_result;
      end
      if (tag_out.vld && tag_out.is_i) begin
        i_data_r    <= bus.mix_result;
        q_data_r    <= q_hold;
        out_valid_r <= 1'b1;
        sym_end_r   <= tag_out.last;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            hold        <= bus.in_data;
            ph          <= ph_next;
            mix_phase_r <= ph_next;
            mix_start_r <= 1'b1;
            state       <= ISSUE_Q;
          end
        end
        ISSUE_Q: begin
          mix_phase_r <= ph + 4'd4;
          state       <= ISSUE_I;
        end
        ISSUE_I: begin
          ph <= ph_next;
          if (accept) begin
            hold        <= bus.in_data;
            mix_phase_r <= ph_next;
            state       <= ISSUE_Q;
          end else begin
            mix_start_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          mix_start_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.mix_start = mix_start_r;
  assign bus.mix_phase = mix_phase_r;
  assign bus.mix_data  = hold;
  assign bus.i_data    = i_data_r;
  assign bus.q_data    = q_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sym_end   = sym_end_r;
  assign bus.busy      = (state != IDLE) | tags_busy | out_valid_r;

endmodule

// File: tb/tb_carrier_mix_sched.sv
// Bench for carrier_mix_sched: cycle table, directed corner sequences and a random run against a queue model.
module tb_carrier_mix_sched;
  localparam int WIDTH   = 16;
  localparam int MIX_LAT = 2;
`ifdef CARRIER_MIX_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  carrier_mix_sched_if #(.WIDTH(WIDTH)) bus ();
  carrier_mix_sched #(.WIDTH(WIDTH), .MIX_LAT(MIX_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit mode  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mixer stand-in: mode 0 returns the phase index, mode 1 a data/phase mix.
  function automatic logic [15:0] mixf(input logic [15:0] d, input logic [3:0] p, input bit m);
    return m ? (d ^ {p, p, p, p}) : {12'h000, p};
  endfunction

  logic [3:0]  hph [MIX_LAT];
  logic [15:0] hd  [MIX_LAT];
  always @(posedge clk) begin
    hph[0] <= bus.mix_phase;
    hd[0]  <= bus.mix_data;
    for (int k = 1; k < MIX_LAT; k++) begin
      hph[k] <= hph[k-1];
      hd[k]  <= hd[k-1];
    end
  end
  assign bus.mix_result = mixf(hd[MIX_LAT-1], hph[MIX_LAT-1], mode);

  // Reference model: each accepted sample takes the next phase of a mod-16 count.
  typedef struct {
    logic [3:0]  ph;
    logic [15:0] d;
  } req_t;
  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        se;
    int          cyc;
  } out_t;

  req_t       req_q[$];
  out_t       out_q[$];
  logic [3:0] mph = 4'd0;
  int         cyc = 0;
  int         ov_cnt = 0;
  int         se_cnt = 0;
  req_t       mr;
  out_t       mo;
  logic [3:0] mp;
  logic [3:0] mpi;

  always @(posedge clk) begin
    if (!rst_n) begin
      req_q.delete();
      out_q.delete();
      mph = 4'd0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        mp   = (SYNC_EN && bus.sync) ? 4'd0 : mph;
        mph  = mp + 4'd1;
        mpi  = mp + 4'd4;
        mr.ph = mp;  mr.d = bus.in_data; req_q.push_back(mr);
        mr.ph = mpi; mr.d = bus.in_data; req_q.push_back(mr);
        mo.i   = mixf(bus.in_data, mpi, mode);
        mo.q   = mixf(bus.in_data, mp, mode);
        mo.se  = (mp == 4'd15);
        mo.cyc = cyc + MIX_LAT + 3;
        out_q.push_back(mo);
      end
      if (bus.mix_start) begin
        chk("request_expected", req_q.size() != 0, 1'b1);
        if (req_q.size() != 0) begin
          mr = req_q.pop_front();
          chk("req_phase", bus.mix_phase, mr.ph);
          chk("req_data", bus.mix_data, mr.d);
        end
      end
      if (bus.out_valid) begin
        ov_cnt++;
        if (bus.sym_end) se_cnt++;
        chk("out_expected", out_q.size() != 0, 1'b1);
        if (out_q.size() != 0) begin
          mo = out_q.pop_front();
          chk("out_i", bus.i_data, mo.i);
          chk("out_q", bus.q_data, mo.q);
          chk("out_sym_end", bus.sym_end, mo.se);
          chk("out_latency", cyc, mo.cyc);
        end
      end
    end
    cyc++;
  end

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] dat;
    logic        rdy;
    logic        st;
    logic [3:0]  ph;
    logic [15:0] md;
    logic        ov;
    logic [15:0] i;
    logic [15:0] q;
    logic        busy;
  } vec_t;
  vec_t vecs [7];

  task automatic do_reset();
    bus.enable   = 1'b0;
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input int n, input bit sync_first);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 4 * n + 20) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      bus.sync     = sync_first && (got == 0);
      @(posedge clk);
      if (bus.in_ready) got++;
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
    chk("stream_accepts", got, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int ov0;
    int se0;
    bit found;

    vecs[0] = '{1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 16'h1000, 1'b0, 16'h0, 16'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd4, 16'h1000, 1'b0, 16'h0, 16'h0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h1000, 1'b0, 16'h0, 16'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h1000, 1'b0, 16'h0, 16'h0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h1000, 1'b1, 16'h4, 16'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h1000, 1'b0, 16'h4, 16'h0, 1'b0};

    bus.enable   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.sync     = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_mix_start", bus.mix_start, 1'b0);
    chk("rst_mix_phase", bus.mix_phase, 4'd0);
    chk("rst_mix_data", bus.mix_data, 16'h0);
    chk("rst_i_data", bus.i_data, 16'h0);
    chk("rst_q_data", bus.q_data, 16'h0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sym_end", bus.sym_end, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single sample 0x1000, mixer echoes phase index.
    mode = 1'b0;
    for (int r = 0; r < 7; r++) begin
      bus.enable   = vecs[r].en;
      bus.in_valid = vecs[r].vld;
      bus.in_data  = vecs[r].dat;
      @(negedge clk);
      chk("vec_in_ready", bus.in_ready, vecs[r].rdy);
      chk("vec_mix_start", bus.mix_start, vecs[r].st);
      chk("vec_mix_phase", bus.mix_phase, vecs[r].ph);
      chk("vec_mix_data", bus.mix_data, vecs[r].md);
      chk("vec_out_valid", bus.out_valid, vecs[r].ov);
      chk("vec_i_data", bus.i_data, vecs[r].i);
      chk("vec_q_data", bus.q_data, vecs[r].q);
      chk("vec_sym_end", bus.sym_end, 1'b0);
      chk("vec_busy", bus.busy, vecs[r].busy);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    mode = 1'b1;

    // enable dropped during ISSUE_Q: no further accept, pending pair drains, busy falls after it.
    bus.enable = 1'b1;
    send_stream(1, 1'b0);
    bus.enable   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_low_in_ready", bus.in_ready, 1'b0);
    chk("en_low_i_request", bus.mix_start, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_low_no_new_request", bus.mix_start, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (bus.out_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("en_low_pair_emerges", found, 1'b1);
    chk("en_low_busy_at_out", bus.busy, 1'b1);
    @(negedge clk);
    chk("en_low_busy_after_out", bus.busy, 1'b0);
    chk("en_low_still_idle", bus.mix_start, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.enable   = 1'b1;
    drain();

    // 32 back-to-back samples from phase 0.
    do_reset();
    bus.enable = 1'b1;
    ov0 = ov_cnt;
    se0 = se_cnt;
    acc = 0;
    for (int k = 0; k < 64; k++) begin
      bus.in_valid = (acc < 32);
      bus.in_data  = 16'($urandom);
      @(negedge clk);
      chk("b2b_in_ready", bus.in_ready, (k % 2 == 0));
      chk("b2b_mix_start", bus.mix_start, (k > 0));
      @(posedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      #1;
    end
    drain();
    chk("b2b_out_count", ov_cnt - ov0, 32);
    chk("b2b_sym_end_count", se_cnt - se0, 2);

    // Gap after three samples: the fourth resumes at phase 3.
    do_reset();
    bus.enable = 1'b1;
    send_stream(3, 1'b0);
    drain();
    send_stream(1, 1'b0);
    @(negedge clk);
    chk("gap_q_phase", bus.mix_phase, 4'd3);
    @(negedge clk);
    chk("gap_i_phase", bus.mix_phase, 4'd7);
    @(posedge clk); #1;
    drain();

    // sync on sample 5.
    do_reset();
    bus.enable = 1'b1;
    se0 = se_cnt;
    send_stream(5, 1'b0);
    send_stream(1, 1'b1);
    @(negedge clk);
    chk("sync_q_phase", bus.mix_phase, SYNC_EN ? 4'd0 : 4'd5);
    @(negedge clk);
    chk("sync_i_phase", bus.mix_phase, SYNC_EN ? 4'd4 : 4'd9);
    @(posedge clk); #1;
    send_stream(16, 1'b0);
    drain();
    chk("sync_sym_end_count", se_cnt - se0, 1);

    // Reset between Q and I requests.
    send_stream(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mix_start", bus.mix_start, 1'b0);
    chk("midrst_mix_phase", bus.mix_phase, 4'd0);
    chk("midrst_mix_data", bus.mix_data, 16'h0);
    chk("midrst_i_data", bus.i_data, 16'h0);
    chk("midrst_q_data", bus.q_data, 16'h0);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_sym_end", bus.sym_end, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ov0 = ov_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_out_valid", ov_cnt - ov0, 0);
    send_stream(1, 1'b0);
    @(negedge clk);
    chk("midrst_next_q_phase", bus.mix_phase, 4'd0);
    @(negedge clk);
    chk("midrst_next_i_phase", bus.mix_phase, 4'd4);
    @(posedge clk); #1;
    drain();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus.enable   = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 4) < 3);
      bus.in_data  = 16'($urandom);
      bus.sync     = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    bus.enable = 1'b1;
    drain();
    chk("final_requests_drained", req_q.size(), 0);
    chk("final_outputs_drained", out_q.size(), 0);
    chk("final_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
